// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory controller slice: default parameter
// values and the transaction FSM state encoding.
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_WAIT_STATES = 2;

    // IDLE is the only state in which requests and address loads are accepted.
    typedef enum logic [2:0] {
        IDLE,
        READ_ROM,
        READ_RAM,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_e;

endpackage : mem_pkg

// File: rtl/mem_address_reg.sv
// ---------------------------------------------------------------------------
// mem_address_reg
// Address register shared by ROM and RAM accesses. Supports a parallel load
// and a +1 increment that wraps from all-ones back to zero.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset (clears the address)
//   i_load       load i_loadValue (has priority over i_inc)
//   i_loadValue  value to load
//   i_inc        increment by one, modulo 2^ADDR_WIDTH
//   o_address    current address
// ---------------------------------------------------------------------------
module mem_address_reg #(
    parameter int ADDR_WIDTH = mem_pkg::DEF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_loadValue,
    input  logic                  i_inc,
    output logic [ADDR_WIDTH-1:0] o_address
);

    logic [ADDR_WIDTH-1:0] address_q;
    logic [ADDR_WIDTH-1:0] address_d;

    always_comb begin
        address_d = address_q;
        if (i_load) begin
            address_d = i_loadValue;
        end else if (i_inc) begin
            // Natural overflow of the fixed-width add gives the wrap to 0.
            address_d = address_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values of all others, independent of process ordering.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            address_q <= '0;
        end else begin
            address_q <= address_d;
        end
    end

    assign o_address = address_q;

endmodule : mem_address_reg

// File: rtl/memory_controller.sv
// ---------------------------------------------------------------------------
// memory_controller
// Sequences single-word reads from a combinational program ROM (two banks)
// and reads/writes to an asynchronous RAM with active-low strobes. One
// transaction at a time; requests are ignored while busy.
//
// Ports
//   i_clk, i_rst                 clock / async active-high reset
//   i_address, i_addressEn       address load (IDLE only)
//   i_addressInc                 post-increment after the accepted transaction
//   i_readReq, i_writeReq        requests (write wins if both)
//   i_writeData                  write data, latched at accept
//   i_readDataSelect             read source: 1 = RAM, 0 = ROM
//   i_immediateSelect            ROM bank: 1 = immediate, 0 = program
//   o_readData, o_readValid      last read word / one-cycle new-data pulse
//   o_writeDone                  one-cycle write-complete pulse
//   o_busy                       transaction in progress
//   o_collision                  one-cycle pulse: read+write requested together
//   o_romAddress, i_romData      ROM interface ({bank, address})
//   o_ramAddress, o_ramWriteData RAM address / write data
//   o_ramNWe, o_ramNOe           registered active-low RAM strobes
//   i_ramReadData                RAM read data
// ---------------------------------------------------------------------------
module memory_controller
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic                  i_addressEn,
    input  logic                  i_addressInc,
    input  logic                  i_readReq,
    input  logic                  i_writeReq,
    input  logic [DATA_WIDTH-1:0] i_writeData,
    input  logic                  i_readDataSelect,
    input  logic                  i_immediateSelect,
    output logic [DATA_WIDTH-1:0] o_readData,
    output logic                  o_readValid,
    output logic                  o_writeDone,
    output logic                  o_busy,
    output logic                  o_collision,
    output logic [ADDR_WIDTH:0]   o_romAddress,
    input  logic [DATA_WIDTH-1:0] i_romData,
    output logic [ADDR_WIDTH-1:0] o_ramAddress,
    output logic [DATA_WIDTH-1:0] o_ramWriteData,
    output logic                  o_ramNWe,
    output logic                  o_ramNOe,
    input  logic [DATA_WIDTH-1:0] i_ramReadData
);

    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  rom_bank_q, rom_bank_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  inc_pending_q, inc_pending_d;
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                  read_valid_q, read_valid_d;
    logic                  write_done_q, write_done_d;
    logic                  collision_q, collision_d;
    logic                  ram_nwe_q, ram_nwe_d;
    logic                  ram_noe_q, ram_noe_d;

    logic                  accept;
    logic                  wait_done;
    logic                  addr_load;
    logic                  addr_inc;
    logic [ADDR_WIDTH-1:0] address;

    assign accept    = (state_q == IDLE) && (i_readReq || i_writeReq);
    assign wait_done = (wait_cnt_q == '0);
    assign addr_load = (state_q == IDLE) && i_addressEn;
    // Increment lands on the edge that takes the FSM back to IDLE.
    assign addr_inc  = inc_pending_q && (state_q != IDLE) && (state_d == IDLE);

    mem_address_reg #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_address_reg (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (addr_load),
        .i_loadValue (i_address),
        .i_inc       (addr_inc),
        .o_address   (address)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_writeReq) begin
                    state_d = WR_SETUP;
                end else if (i_readReq) begin
                    state_d = i_readDataSelect ? READ_RAM : READ_ROM;
                end
            end
            READ_ROM: state_d = IDLE;
            READ_RAM: if (wait_done) state_d = IDLE;
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: if (wait_done) state_d = WR_HOLD;
            WR_HOLD:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        wait_cnt_d    = wait_cnt_q;
        rom_bank_d    = rom_bank_q;
        wdata_d       = wdata_q;
        inc_pending_d = inc_pending_q;
        read_data_d   = read_data_q;

        // Wait counter reloads on entry to a timed state and counts down to 0.
        if ((state_d != state_q) && ((state_d == READ_RAM) || (state_d == WR_PULSE))) begin
            wait_cnt_d = CNT_W'(WAIT_STATES - 1);
        end else if (!wait_done) begin
            wait_cnt_d = wait_cnt_q - 1'b1;
        end

        if (accept) begin
            inc_pending_d = i_addressInc;
            if (i_writeReq) begin
                wdata_d = i_writeData;
            end else begin
                rom_bank_d = i_immediateSelect;
            end
        end

        if (state_q == READ_ROM) begin
            read_data_d = i_romData;
        end else if ((state_q == READ_RAM) && wait_done) begin
            read_data_d = i_ramReadData;
        end

        read_valid_d = (state_q == READ_ROM) || ((state_q == READ_RAM) && wait_done);
        write_done_d = (state_q == WR_HOLD);
        collision_d  = accept && i_readReq && i_writeReq;

        // Strobes are registered from the next state so they track state_q
        // exactly and can never glitch or overlap.
        ram_noe_d = (state_d != READ_RAM);
        ram_nwe_d = (state_d != WR_PULSE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wait_cnt_q    <= '0;
            rom_bank_q    <= 1'b0;
            wdata_q       <= '0;
            inc_pending_q <= 1'b0;
            read_data_q   <= '0;
            read_valid_q  <= 1'b0;
            write_done_q  <= 1'b0;
            collision_q   <= 1'b0;
            ram_nwe_q     <= 1'b1;
            ram_noe_q     <= 1'b1;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            rom_bank_q    <= rom_bank_d;
            wdata_q       <= wdata_d;
            inc_pending_q <= inc_pending_d;
            read_data_q   <= read_data_d;
            read_valid_q  <= read_valid_d;
            write_done_q  <= write_done_d;
            collision_q   <= collision_d;
            ram_nwe_q     <= ram_nwe_d;
            ram_noe_q     <= ram_noe_d;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_busy         = (state_q != IDLE);
        o_readData     = read_data_q;
        o_readValid    = read_valid_q;
        o_writeDone    = write_done_q;
        o_collision    = collision_q;
        o_romAddress   = {rom_bank_q, address};
        o_ramAddress   = address;
        o_ramWriteData = wdata_q;
        o_ramNWe       = ram_nwe_q;
        o_ramNOe       = ram_noe_q;
    end

endmodule : memory_controller

// File: tb/tb_memory_controller.sv
// ---------------------------------------------------------------------------
// tb_memory_controller
// Directed bench for memory_controller with default parameters
// (8-bit data, 8-bit address, WAIT_STATES = 2). Provides a behavioural RAM
// and a combinational ROM; inputs change and outputs are sampled 1 ns after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_memory_controller;

    logic       clk;
    logic       rst;
    logic [7:0] address;
    logic       address_en;
    logic       address_inc;
    logic       read_req;
    logic       write_req;
    logic [7:0] write_data;
    logic       read_sel;
    logic       imm_sel;
    logic [7:0] read_data;
    logic       read_valid;
    logic       write_done;
    logic       busy;
    logic       collision;
    logic [8:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_nwe;
    logic       ram_noe;
    logic [7:0] ram_rdata;

    logic [7:0] ram_mem [256];

    int n_vec  = 0;
    int n_miss = 0;

    // Per-transaction observation results.
    int         busy_cnt, nwe_low_cnt, noe_low_cnt;
    int         valid_cnt, done_cnt, coll_cnt;
    int         valid_at, done_at, coll_at, both_low;
    logic [8:0] rom_addr_c1;

    memory_controller dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_address         (address),
        .i_addressEn       (address_en),
        .i_addressInc      (address_inc),
        .i_readReq         (read_req),
        .i_writeReq        (write_req),
        .i_writeData       (write_data),
        .i_readDataSelect  (read_sel),
        .i_immediateSelect (imm_sel),
        .o_readData        (read_data),
        .o_readValid       (read_valid),
        .o_writeDone       (write_done),
        .o_busy            (busy),
        .o_collision       (collision),
        .o_romAddress      (rom_addr),
        .i_romData         (rom_data),
        .o_ramAddress      (ram_addr),
        .o_ramWriteData    (ram_wdata),
        .o_ramNWe          (ram_nwe),
        .o_ramNOe          (ram_noe),
        .i_ramReadData     (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: immediate-bank word 0x10 holds 0xA5, every other word echoes its
    // low address bits.
    assign rom_data  = (rom_addr == 9'h110) ? 8'hA5 : rom_addr[7:0];
    assign ram_rdata = ram_mem[ram_addr];

    always @(posedge clk) begin
        if (!ram_nwe) ram_mem[ram_addr] <= ram_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_addr(input logic [7:0] a);
        address    = a;
        address_en = 1'b1;
        tick();
        address_en = 1'b0;
    endtask

    // Runs n cycles after the accept edge; requests drop after the first one.
    task automatic observe(input int n);
        busy_cnt = 0; nwe_low_cnt = 0; noe_low_cnt = 0;
        valid_cnt = 0; done_cnt = 0; coll_cnt = 0;
        valid_at = 0; done_at = 0; coll_at = 0; both_low = 0;
        for (int c = 1; c <= n; c++) begin
            tick();
            if (c == 1) begin
                read_req    = 1'b0;
                write_req   = 1'b0;
                address_inc = 1'b0;
                rom_addr_c1 = rom_addr;
            end
            if (busy)     busy_cnt++;
            if (!ram_nwe) nwe_low_cnt++;
            if (!ram_noe) noe_low_cnt++;
            if (!ram_nwe && !ram_noe) both_low = 1;
            if (read_valid) begin valid_cnt++; if (valid_at == 0) valid_at = c; end
            if (write_done) begin done_cnt++;  if (done_at  == 0) done_at  = c; end
            if (collision)  begin coll_cnt++;  if (coll_at  == 0) coll_at  = c; end
        end
    endtask

    initial begin
        rst = 1'b1; address = '0; address_en = 0; address_inc = 0;
        read_req = 0; write_req = 0; write_data = '0; read_sel = 0; imm_sel = 0;

        // ---- reset state ----
        tick(); tick();
        check("rst_busy",  busy, 0);
        check("rst_nwe",   ram_nwe, 1);
        check("rst_noe",   ram_noe, 1);
        check("rst_rdata", read_data, 0);
        check("rst_pulses", {read_valid, write_done, collision}, 0);
        check("rst_addr",  ram_addr, 0);
        rst = 1'b0;
        tick();

        // ---- ROM read, immediate bank ----
        load_addr(8'h10);
        check("load_addr", ram_addr, 8'h10);
        read_req = 1; read_sel = 0; imm_sel = 1;
        observe(4);
        check("rom_addr",     rom_addr_c1, 9'h110);
        check("rom_rdata",    read_data, 8'hA5);
        check("rom_valid_at", valid_at, 2);
        check("rom_valid_n",  valid_cnt, 1);
        check("rom_busy",     busy_cnt, 1);

        // ---- RAM write then read back ----
        load_addr(8'h20);
        write_req = 1; write_data = 8'h3C; read_sel = 0;
        observe(6);
        check("wr_nwe_low", nwe_low_cnt, 2);
        check("wr_busy",    busy_cnt, 4);
        check("wr_done_n",  done_cnt, 1);
        check("wr_done_at", done_at, 5);
        check("wr_noe_low", noe_low_cnt, 0);
        check("wr_ram",     ram_mem[8'h20], 8'h3C);
        read_req = 1; read_sel = 1;
        observe(5);
        check("rd_valid_at", valid_at, 3);
        check("rd_rdata",    read_data, 8'h3C);
        check("rd_noe_low",  noe_low_cnt, 2);
        check("rd_overlap",  both_low, 0);
        check("rd_addr_keep", ram_addr, 8'h20);

        // ---- address wrap with post-increment ----
        load_addr(8'hFF);
        write_req = 1; write_data = 8'h77;
        observe(6);
        read_req = 1; read_sel = 1; address_inc = 1;
        observe(5);
        check("wrap_rdata", read_data, 8'h77);
        check("wrap_addr",  ram_addr, 8'h00);

        // ---- collision: write wins ----
        load_addr(8'h30);
        read_req = 1; write_req = 1; read_sel = 1; write_data = 8'h99;
        observe(6);
        check("col_n",     coll_cnt, 1);
        check("col_at",    coll_at, 1);
        check("col_valid", valid_cnt, 0);
        check("col_done",  done_cnt, 1);
        check("col_ram",   ram_mem[8'h30], 8'h99);

        // ---- address load ignored while busy ----
        write_req = 1; write_data = 8'h11;
        tick();
        write_req = 0; address = 8'h55; address_en = 1;
        for (int i = 0; i < 3; i++) tick();
        address_en = 0;
        tick(); tick();
        check("busy_load", ram_addr, 8'h30);

        // ---- back-to-back ROM reads, then read data hold ----
        load_addr(8'h10);
        read_req = 1; read_sel = 0; imm_sel = 0;
        tick();
        check("b2b_busy1", busy, 1);
        tick();
        check("b2b_valid", {busy, read_valid}, 2'b01);
        check("b2b_rdata", read_data, 8'h10);
        tick();
        check("b2b_busy2", busy, 1);
        read_req = 0;
        tick();
        load_addr(8'h33);
        tick(); tick();
        check("hold_rdata", read_data, 8'h10);
        check("hold_valid", read_valid, 0);

        // ---- reset during write pulse ----
        load_addr(8'h40);
        write_req = 1; write_data = 8'hEE; address_inc = 1;
        tick();
        write_req = 0; address_inc = 0;
        tick();
        check("mid_nwe_low", ram_nwe, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_nwe",  ram_nwe, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", ram_addr, 0);
        tick(); tick();
        rst = 1'b0;
        observe(6);
        check("mid_rst_done",  done_cnt, 0);
        check("mid_rst_idle",  busy_cnt, 0);
        check("mid_rst_rdata", read_data, 0);
        check("mid_rst_addr2", ram_addr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_memory_controller
